// File: rtl/pc_ir_unit_if.sv
// Memory handshake between the PC/IR front end and instruction/data memory.
// The front end is the master: it drives the address and the fetch request.
interface pc_ir_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] mem_addr;
    logic             mem_req;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/pc_ir_unit.sv
// Multicycle datapath front end: PC, IR, MDR and ALUOut registers, memory address
// select, conditional PC update and the instruction fetch handshake with timeout.
//
// state  | meaning
// S_IDLE | no fetch outstanding; IRWrite starts one (zero-wait if mem_ready)
// S_WAIT | fetch outstanding; waiting for mem_ready or the timeout
module pc_ir_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWrite_i,
    input  logic [1:0]        PCWriteCond_i,
    input  logic [1:0]        PCSource_i,
    input  logic              IorD_i,
    input  logic              IRWrite_i,
    input  logic [WIDTH-1:0]  alu_result_i,
    input  logic              alu_zero_i,
    input  logic              alu_neg_i,
    input  logic [WIDTH-1:0]  reg_a_i,
    pc_ir_unit_if.master      mem,
    output logic [WIDTH-1:0]  pc_o,
    output logic [31:0]       ir_o,
    output logic [5:0]        opCode_o,
    output logic [WIDTH-1:0]  mdr_o,
    output logic [WIDTH-1:0]  alu_out_o,
    output logic              stall_o,
    output logic              fetch_err_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              fetch_done, fetch_abort;
    logic              stall;

    logic [WIDTH-1:0]  pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [WIDTH-1:0]  mdr_q, mdr_d;
    logic [WIDTH-1:0]  alu_out_q, alu_out_d;
    logic              err_q, err_d;

    logic              take;
    logic [WIDTH-1:0]  jump_tgt;
    logic [WIDTH-1:0]  pc_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fetch_done  = 1'b0;
        fetch_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (IRWrite_i) begin
                    if (mem.mem_ready) begin
                        fetch_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (mem.mem_ready) begin
                    fetch_done = 1'b1;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end else if (cnt_q == CNT_MAX) begin
                    fetch_abort = 1'b1;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall drops in the cycle the fetch resolves so control_unit advances on that edge.
    always_comb begin
        mem.mem_req = 1'b0;
        stall       = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem.mem_req = IRWrite_i;
                stall       = IRWrite_i & ~mem.mem_ready;
            end
            S_WAIT: begin
                mem.mem_req = 1'b1;
                stall       = ~(mem.mem_ready | (cnt_q == CNT_MAX));
            end
            default: begin
                mem.mem_req = 1'b0;
                stall       = 1'b0;
            end
        endcase
    end

    always_comb begin
        take = PCWrite_i;
        case (PCWriteCond_i)
            2'b01:   take = PCWrite_i | alu_zero_i;
            2'b10:   take = PCWrite_i | ~alu_zero_i;
            2'b11:   take = PCWrite_i | alu_neg_i | alu_zero_i;
            default: take = PCWrite_i;
        endcase
    end

    // Jump keeps the upper PC bits of the current (pre-update) PC.
    always_comb begin
        jump_tgt        = pc_q;
        jump_tgt[27:0]  = {ir_q[25:0], 2'b00};
        case (PCSource_i)
            2'b00:   pc_src = alu_result_i;
            2'b01:   pc_src = alu_out_q;
            2'b10:   pc_src = jump_tgt;
            default: pc_src = reg_a_i;
        endcase
    end

    always_comb begin
        pc_d      = (take && !stall) ? pc_src : pc_q;
        alu_out_d = alu_result_i;
        mdr_d     = mem.mem_ready ? mem.mem_rdata : mdr_q;
        ir_d      = ir_q;
        err_d     = err_q;
        if (fetch_done) begin
            ir_d = mem.mem_rdata[31:0];
        end else if (fetch_abort) begin
            ir_d  = '0;
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mdr_q     <= '0;
            alu_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            alu_out_q <= alu_out_d;
            err_q     <= err_d;
        end
    end

    assign mem.mem_addr = IorD_i ? alu_out_q : pc_q;
    assign pc_o         = pc_q;
    assign ir_o         = ir_q;
    assign opCode_o     = ir_q[31:26];
    assign mdr_o        = mdr_q;
    assign alu_out_o    = alu_out_q;
    assign stall_o      = stall;
    assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Bench for pc_ir_unit: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of fetch age, PC and data registers.
module tb_pc_ir_unit;
    localparam int          W   = 32;
    localparam logic [31:0] RPC = 32'h0;
    localparam int          TO  = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        pc_write, iord, ir_write, alu_zero, alu_neg;
    logic [1:0]  pc_cond, pc_src;
    logic [31:0] alu_result, reg_a;
    logic [31:0] pc, ir, mdr, alu_out;
    logic [5:0]  opcode;
    logic        stall, fetch_err;

    pc_ir_unit_if #(.WIDTH(W)) bus ();

    pc_ir_unit #(.WIDTH(W), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .PCWrite_i(pc_write), .PCWriteCond_i(pc_cond), .PCSource_i(pc_src),
        .IorD_i(iord), .IRWrite_i(ir_write),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero), .alu_neg_i(alu_neg),
        .reg_a_i(reg_a), .mem(bus),
        .pc_o(pc), .ir_o(ir), .opCode_o(opcode), .mdr_o(mdr), .alu_out_o(alu_out),
        .stall_o(stall), .fetch_err_o(fetch_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a fetch is "busy" from its first request cycle until it resolves;
    // m_age counts the cycles it has been outstanding (0 in the request cycle).
    logic [31:0] m_pc, m_ir, m_mdr, m_alu;
    bit          m_busy, m_err;
    int          m_age;

    function automatic bit exp_req();
        return m_busy || (ir_write === 1'b1);
    endfunction

    function automatic bit exp_done();
        return exp_req() && ((bus.mem_ready === 1'b1) || (m_age == TO));
    endfunction

    function automatic bit exp_stall();
        return exp_req() && !exp_done();
    endfunction

    function automatic logic [31:0] exp_addr();
        return iord ? m_alu : m_pc;
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_ir = 0; m_mdr = 0; m_alu = 0;
        m_busy = 0; m_err = 0; m_age = 0;
    endtask

    task automatic idle_inputs();
        pc_write = 0; pc_cond = 0; pc_src = 0; iord = 0; ir_write = 0;
        alu_result = 0; alu_zero = 0; alu_neg = 0; reg_a = 0;
        bus.mem_rdata = 0; bus.mem_ready = 0;
    endtask

    // Advance one clock, moving the model along with the inputs currently applied.
    task automatic edge_step();
        bit          take, done, req;
        logic [31:0] tgt, n_pc, n_ir, n_mdr;
        bit          n_busy, n_err;
        int          n_age;
        take = pc_write
            || (pc_cond == 2'b01 && alu_zero)
            || (pc_cond == 2'b10 && !alu_zero)
            || (pc_cond == 2'b11 && (alu_neg || alu_zero));
        case (pc_src)
            2'b00:   tgt = alu_result;
            2'b01:   tgt = m_alu;
            2'b10:   tgt = (m_pc & 32'hF000_0000) + ({6'b0, m_ir[25:0]} * 4);
            default: tgt = reg_a;
        endcase
        req    = exp_req();
        done   = exp_done();
        n_pc   = (take && !exp_stall()) ? tgt : m_pc;
        n_ir   = m_ir; n_err = m_err; n_busy = m_busy; n_age = m_age;
        if (done) begin
            if (bus.mem_ready) n_ir = bus.mem_rdata;
            else begin n_ir = 0; n_err = 1; end
            n_busy = 0; n_age = 0;
        end else if (req) begin
            n_busy = 1; n_age = m_age + 1;
        end
        n_mdr = bus.mem_ready ? bus.mem_rdata : m_mdr;
        @(posedge clk);
        m_alu = alu_result;
        m_pc = n_pc; m_ir = n_ir; m_mdr = n_mdr; m_err = n_err;
        m_busy = n_busy; m_age = n_age;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2 reset = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (pc !== RPC) $display("FAIL reset_pc got=%h exp=%h", pc, RPC); else n_pass++;
        n_checks++; if (ir !== 32'h0) $display("FAIL reset_ir got=%h exp=0", ir); else n_pass++;
        n_checks++; if (opcode !== 6'h0) $display("FAIL reset_opcode got=%h exp=0", opcode); else n_pass++;
        n_checks++; if (mdr !== 32'h0 || alu_out !== 32'h0) $display("FAIL reset_mdr_aluout got=%h/%h exp=0/0", mdr, alu_out); else n_pass++;
        n_checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0 || fetch_err !== 1'b0) $display("FAIL reset_ctrl req/stall/err got=%b%b%b exp=000", bus.mem_req, stall, fetch_err); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_zero_wait_fetch();
        bit seen_stall = 0;
        ir_write = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h2008_0005;
        #1;
        if (stall !== 1'b0) seen_stall = 1;
        n_checks++; if (bus.mem_req !== 1'b1) $display("FAIL zw_req got=%b exp=1", bus.mem_req); else n_pass++;
        edge_step();
        if (stall !== 1'b0) seen_stall = 1;
        idle_inputs();
        #1;
        if (stall !== 1'b0) seen_stall = 1;
        n_checks++; if (seen_stall) $display("FAIL zw_stall got=1 exp=never"); else n_pass++;
        n_checks++; if (ir !== 32'h2008_0005) $display("FAIL zw_ir got=%h exp=20080005", ir); else n_pass++;
        n_checks++; if (opcode !== 6'h08) $display("FAIL zw_opcode got=%h exp=08", opcode); else n_pass++;
        n_checks++; if (mdr !== 32'h2008_0005) $display("FAIL zw_mdr got=%h exp=20080005", mdr); else n_pass++;
        edge_step();
    endtask

    task automatic test_wait_fetch();
        int          n_stall = 0, n_req = 0;
        logic [31:0] pc0, ir0;
        pc0 = pc; ir0 = ir;
        for (int k = 0; k < 4; k++) begin
            ir_write      = (k == 0);
            bus.mem_ready = (k == 3);
            bus.mem_rdata = (k == 3) ? 32'h8C41_0004 : 32'hDEAD_BEEF;
            pc_write = 1; pc_src = 2'b00; alu_result = 32'h0000_1234;
            #1;
            if (stall === 1'b1) n_stall++;
            if (bus.mem_req === 1'b1) n_req++;
            edge_step();
            if (k < 3) begin
                n_checks++; if (ir !== ir0) $display("FAIL wait_ir_early k=%0d got=%h exp=%h", k, ir, ir0); else n_pass++;
                n_checks++; if (pc !== pc0) $display("FAIL wait_pc_held k=%0d got=%h exp=%h", k, pc, pc0); else n_pass++;
            end
        end
        idle_inputs();
        #1;
        n_checks++; if (n_stall != 3) $display("FAIL wait_stall_cycles got=%0d exp=3", n_stall); else n_pass++;
        n_checks++; if (n_req != 4) $display("FAIL wait_req_cycles got=%0d exp=4", n_req); else n_pass++;
        n_checks++; if (ir !== 32'h8C41_0004) $display("FAIL wait_ir got=%h exp=8c410004", ir); else n_pass++;
        n_checks++; if (pc !== 32'h0000_1234) $display("FAIL wait_pc_on_done got=%h exp=00001234", pc); else n_pass++;
        n_checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL wait_idle req/stall got=%b%b exp=00", bus.mem_req, stall); else n_pass++;
    endtask

    task automatic test_branch_cond();
        logic [31:0] pc0;
        idle_inputs(); alu_result = 32'h40; #1; edge_step();
        pc_cond = 2'b01; alu_zero = 1; pc_src = 2'b01; alu_result = 32'h80; #1; edge_step();
        n_checks++; if (pc !== 32'h40) $display("FAIL beq_taken got=%h exp=00000040", pc); else n_pass++;
        pc0 = pc;
        pc_cond = 2'b01; alu_zero = 0; pc_src = 2'b01; alu_result = 32'hC0; #1; edge_step();
        n_checks++; if (pc !== pc0) $display("FAIL beq_not_taken got=%h exp=%h", pc, pc0); else n_pass++;
        pc_cond = 2'b10; alu_zero = 0; pc_src = 2'b01; alu_result = 32'h100; #1; edge_step();
        n_checks++; if (pc !== 32'hC0) $display("FAIL bne_taken got=%h exp=000000c0", pc); else n_pass++;
        pc_cond = 2'b11; alu_zero = 0; alu_neg = 1; pc_src = 2'b11; reg_a = 32'h0000_0ABC; #1; edge_step();
        n_checks++; if (pc !== 32'h0000_0ABC) $display("FAIL ble_neg_taken got=%h exp=00000abc", pc); else n_pass++;
        pc_cond = 2'b11; alu_zero = 0; alu_neg = 0; pc_src = 2'b11; reg_a = 32'h0000_0FFF; #1; edge_step();
        n_checks++; if (pc !== 32'h0000_0ABC) $display("FAIL ble_not_taken got=%h exp=00000abc", pc); else n_pass++;
        iord = 1; #1;
        n_checks++; if (bus.mem_addr !== 32'h100) $display("FAIL iord_addr got=%h exp=00000100", bus.mem_addr); else n_pass++;
        iord = 0; #1;
        n_checks++; if (bus.mem_addr !== 32'h0000_0ABC) $display("FAIL pc_addr got=%h exp=00000abc", bus.mem_addr); else n_pass++;
        idle_inputs(); #1; edge_step();
    endtask

    task automatic test_jump();
        idle_inputs(); pc_write = 1; pc_src = 2'b00; alu_result = 32'h1000_0000;
        ir_write = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h0800_0100;
        #1; edge_step();
        idle_inputs(); pc_write = 1; pc_src = 2'b10; #1; edge_step();
        n_checks++; if (pc !== 32'h1000_0400) $display("FAIL jump_pc got=%h exp=10000400", pc); else n_pass++;
        idle_inputs(); #1; edge_step();
    endtask

    task automatic test_timeout();
        int n_stall = 0, n_req = 0;
        for (int k = 0; k < 22; k++) begin
            ir_write = (k == 0); bus.mem_ready = 0;
            #1;
            if (stall === 1'b1) n_stall++;
            if (bus.mem_req === 1'b1) n_req++;
            edge_step();
        end
        n_checks++; if (n_stall != TO) $display("FAIL to_stall_cycles got=%0d exp=%0d", n_stall, TO); else n_pass++;
        n_checks++; if (n_req != TO + 1) $display("FAIL to_req_cycles got=%0d exp=%0d", n_req, TO + 1); else n_pass++;
        n_checks++; if (ir !== 32'h0) $display("FAIL to_ir got=%h exp=0", ir); else n_pass++;
        n_checks++; if (fetch_err !== 1'b1) $display("FAIL to_err got=%b exp=1", fetch_err); else n_pass++;
        ir_write = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h0000_0000; #1; edge_step();
        idle_inputs(); #1;
        n_checks++; if (fetch_err !== 1'b1) $display("FAIL to_err_sticky got=%b exp=1", fetch_err); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bit slow;
            slow = ((i / 60) % 3) == 2;
            pc_write   = ($urandom_range(0, 4) == 0);
            pc_cond    = 2'($urandom_range(0, 3));
            pc_src     = 2'($urandom_range(0, 3));
            iord       = 1'($urandom_range(0, 1));
            ir_write   = ($urandom_range(0, 3) == 0);
            alu_result = $urandom();
            alu_zero   = 1'($urandom_range(0, 1));
            alu_neg    = 1'($urandom_range(0, 1));
            reg_a      = $urandom();
            bus.mem_rdata = $urandom();
            bus.mem_ready = slow ? ($urandom_range(0, 29) == 0) : 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (bus.mem_req !== exp_req()) $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, bus.mem_req, exp_req()); else n_pass++;
            n_checks++; if (stall !== exp_stall()) $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", i, stall, exp_stall()); else n_pass++;
            n_checks++; if (bus.mem_addr !== exp_addr()) $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, bus.mem_addr, exp_addr()); else n_pass++;
            edge_step();
            n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", i, pc, m_pc); else n_pass++;
            n_checks++; if (ir !== m_ir || opcode !== m_ir[31:26]) $display("FAIL rnd_ir cyc=%0d got=%h exp=%h", i, ir, m_ir); else n_pass++;
            n_checks++; if (mdr !== m_mdr) $display("FAIL rnd_mdr cyc=%0d got=%h exp=%h", i, mdr, m_mdr); else n_pass++;
            n_checks++; if (alu_out !== m_alu) $display("FAIL rnd_aluout cyc=%0d got=%h exp=%h", i, alu_out, m_alu); else n_pass++;
            n_checks++; if (fetch_err !== m_err) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, fetch_err, m_err); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs(); pc_write = 1; alu_result = 32'h0000_ABC0;
        ir_write = 1; bus.mem_ready = 1; bus.mem_rdata = 32'h1234_5678; #1; edge_step();
        idle_inputs(); ir_write = 1; #1; edge_step();
        ir_write = 0; #1; edge_step();
        n_checks++; if (stall !== 1'b1 || bus.mem_req !== 1'b1) $display("FAIL rmw_in_wait stall/req got=%b%b exp=11", stall, bus.mem_req); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rmw_ctrl req/stall got=%b%b exp=00", bus.mem_req, stall); else n_pass++;
        n_checks++; if (pc !== RPC || ir !== 32'h0 || opcode !== 6'h0) $display("FAIL rmw_pc_ir got=%h/%h exp=%h/0", pc, ir, RPC); else n_pass++;
        n_checks++; if (fetch_err !== 1'b0 || mdr !== 32'h0 || alu_out !== 32'h0) $display("FAIL rmw_regs err/mdr/alu got=%b/%h/%h exp=0/0/0", fetch_err, mdr, alu_out); else n_pass++;
        model_reset();
        reset = 1'b1;
        ir_write = 1; bus.mem_ready = 1; bus.mem_rdata = 32'hAC00_0001; #1;
        n_checks++; if (stall !== 1'b0) $display("FAIL rmw_after_stall got=%b exp=0", stall); else n_pass++;
        edge_step();
        n_checks++; if (ir !== 32'hAC00_0001) $display("FAIL rmw_after_ir got=%h exp=ac000001", ir); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_wait_fetch();
        test_branch_cond();
        test_jump();
        test_timeout();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
